// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch unit.
//   NOP_INSTR  : word returned for misaligned / out-of-range fetches
//   WORD_BYTES : bytes per instruction word
//   BYTE_OFF_W : width of the byte-offset field of a PC
//   state_t    : fetch FSM states (idle, wait-state countdown, response)
package imem_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;
    localparam int          BYTE_OFF_W = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Single-port instruction storage with synchronous write and synchronous read.
// Contents are never reset.
// Ports:
//   clk     : clock
//   i_en    : port enable (read or write this cycle)
//   i_we    : write when enabled, otherwise read
//   i_addr  : word index
//   i_wdata : word to write
//   o_rdata : registered read data, holds its value until the next read
module imem_array #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory for the fetch stage with a registered read
// path, programmable wait states and request/response handshakes.
// Optional feature macro: IMEM_PREFETCH_EN (one-entry next-word buffer).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : fetch request present        req_ready : request accepted
//   req_addr    : byte address (PC)
//   resp_valid  : response available           resp_ready: response consumed
//   resp_data   : instruction word             resp_err  : misaligned/out of range
//   ld_valid    : program-load write request   ld_ready  : load accepted
//   ld_addr     : word index to write          ld_data   : word to write
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int DEPTH       = 1024,
    parameter  int ADDR_W      = 32,
    parameter  int WAIT_STATES = 0,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_err;
    logic              r_hit;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    logic              w_idle;
    logic              w_ld;
    logic              w_accept;
    logic [IDX_W-1:0]  w_req_idx;
    logic              w_req_err;
    logic              w_wait_done;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic              w_pf_rd;
    logic [IDX_W-1:0]  w_pf_addr;
    logic              w_arr_en;
    logic [IDX_W-1:0]  w_arr_addr;
    logic [DATA_W-1:0] w_rdata;

    assign w_idle    = (r_state == ST_IDLE);
    // Loads take priority over fetches, so a pending load masks req_ready.
    assign ld_ready  = w_idle && !rst;
    assign req_ready = w_idle && !rst && !ld_valid;
    assign w_ld      = ld_valid && ld_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_req_idx = req_addr[BYTE_OFF_W +: IDX_W];
    // Any set bit above the index field means the word lies beyond DEPTH.
    assign w_req_err = (req_addr[BYTE_OFF_W-1:0] != '0) ||
                       ((req_addr >> (BYTE_OFF_W + IDX_W)) != '0);

    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == 4'd0);

`ifdef IMEM_PREFETCH_EN
    logic              r_pf_valid;
    logic [IDX_W-1:0]  r_pf_idx;
    logic [DATA_W-1:0] r_pf_data;
    logic [IDX_W-1:0]  r_idx;
    logic              w_next_ok;

    assign w_next_ok  = (r_idx != IDX_W'(DEPTH - 1));
    assign w_hit      = r_pf_valid && !w_req_err && (w_req_idx == r_pf_idx);
    assign w_hit_data = r_pf_data;
    // The array is idle once the response word has been captured, so the
    // next word is read on the same edge that enters RESP.
    assign w_pf_rd    = w_wait_done && !r_err && w_next_ok && !rst;
    assign w_pf_addr  = r_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx <= w_req_idx;
        end
    end

    // The array read for word N+1 landed in w_rdata while in RESP; it is
    // latched into the buffer when the response is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_valid <= 1'b0;
        end else if ((r_state == ST_RESP) && resp_ready && !r_err) begin
            r_pf_valid <= w_next_ok;
            r_pf_idx   <= w_pf_addr;
            r_pf_data  <= w_rdata;
        end else if (w_ld && (ld_addr == r_pf_idx)) begin
            r_pf_valid <= 1'b0;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
    assign w_pf_rd    = 1'b0;
    assign w_pf_addr  = '0;
`endif

    // Erroring fetches never touch the array.
    assign w_arr_en   = w_ld || (w_accept && !w_req_err) || w_pf_rd;
    assign w_arr_addr = w_ld ? ld_addr : (w_pf_rd ? w_pf_addr : w_req_idx);

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_en    (w_arr_en),
        .i_we    (w_ld),
        .i_addr  (w_arr_addr),
        .i_wdata (ld_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_err <= w_req_err;
            r_hit <= w_hit;
        end
    end

    // The first WAIT cycle is the array read cycle; WAIT_STATES adds to it.
    // A buffer hit skips the countdown since no array read is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= w_hit ? 4'd0 : 4'(WAIT_STATES);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_resp_err  <= r_err;
                        r_resp_data <= r_err ? DATA_W'(NOP_INSTR) :
                                       (r_hit ? w_hit_data : w_rdata);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed scenarios with literal expectations
// followed by randomized traffic, checked every cycle against a
// transaction-level model (memory array + outstanding-fetch timestamp).
module tb_imem_fetch_unit;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int WS     = 2;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FULL_LAT = 1 + WS;
`ifdef IMEM_PREFETCH_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 1 + WS;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              ld_valid;
    logic              ld_ready;
    logic [IDX_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;

    imem_fetch_unit #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A fetch is outstanding from its accept edge until the handshake; its
    // response becomes visible once the edge count reaches m_ready_cyc.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy = 0;
    int          m_ready_cyc = 0;
    logic [31:0] m_data;
    bit          m_err;
    int          m_idx;
    bit          m_pf_valid = 0;
    int          m_pf_idx = 0;
    int          cyc = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        int  c_old;
        bit  vld_before;
        int  idx;
        bit  err;
        int  lat;
        c_old = cyc;
        cyc   = cyc + 1;
        vld_before = m_busy && (c_old >= m_ready_cyc);
        if (rst) begin
            m_busy     = 0;
            m_pf_valid = 0;
        end else if (m_busy) begin
            if (vld_before && resp_ready) begin
                m_busy = 0;
                if (!m_err) begin
                    m_pf_valid = (m_idx + 1 < DEPTH);
                    m_pf_idx   = m_idx + 1;
                end
            end
        end else if (ld_valid) begin
            m_mem[ld_addr] = ld_data;
            if (m_pf_valid && int'(ld_addr) == m_pf_idx) m_pf_valid = 0;
        end else if (req_valid) begin
            idx = int'(req_addr / 4);
            err = (req_addr % 4 != 0) || (idx >= DEPTH);
            lat = WS;
`ifdef IMEM_PREFETCH_EN
            if (!err && m_pf_valid && idx == m_pf_idx) lat = 0;
`endif
            m_busy      = 1;
            m_err       = err;
            m_idx       = idx;
            m_data      = err ? 32'h0 : m_mem[idx];
            m_ready_cyc = cyc + 1 + lat;
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = m_busy && (cyc >= m_ready_cyc);
            chk("resp_valid", resp_valid, ev);
            chk("req_ready", req_ready, !m_busy && !rst && !ld_valid);
            chk("ld_ready", ld_ready, !m_busy && !rst);
            if (ev) begin
                chk("resp_data", resp_data, m_data);
                chk("resp_err", resp_err, m_err);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] d,
                         output logic e, output int lat);
        int n;
        req_addr   = addr;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) chk("req_accept", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!resp_valid) chk("resp_arrived", resp_valid, 1'b1);
        d = resp_data;
        e = resp_err;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          last_idx;
        int          k;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          last_idx;
        int          k;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        rst = 1'b0;
        tick();

        // Preload the whole array so every fetch has a defined expectation.
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_addr  = IDX_W'(i);
            ld_data  = (i == 1)  ? 32'h8001_0829 :
                       (i == 2)  ? 32'h8002_0109 :
                       (i == 16) ? 32'hCAFE_0016 : $urandom;
            tick();
        end
        ld_valid = 1'b0;

        // Plain fetch and error fetches.
        fetch(32'h4, d, e, lat);
        chk("w1_lat", lat, FULL_LAT);
        chk("w1_data", d, 32'h8001_0829);
        chk("w1_err", e, 1'b0);
        fetch(32'h6, d, e, lat);
        chk("mis_err", e, 1'b1);
        chk("mis_data", d, 32'h0);
        fetch(32'h1000, d, e, lat);
        chk("oor_err", e, 1'b1);
        chk("oor_data", d, 32'h0);

        // Response held off by resp_ready=0.
        req_addr = 32'h40; req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 40) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", resp_valid, 1'b1);
            chk("hold_data", resp_data, 32'hCAFE_0016);
            chk("hold_err", resp_err, 1'b0);
            chk("hold_req_ready", req_ready, 1'b0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("release_valid", resp_valid, 1'b0);
        chk("release_req_ready", req_ready, 1'b1);

        // Load and request together: load wins, request follows.
        ld_valid = 1'b1; ld_addr = IDX_W'(5); ld_data = 32'h1234_5005;
        req_valid = 1'b1; req_addr = 32'h14;
        #1;
        chk("both_ld_ready", ld_ready, 1'b1);
        chk("both_req_ready", req_ready, 1'b0);
        tick();
        ld_valid = 1'b0;
        fetch(32'h14, d, e, lat);
        chk("ldfetch_data", d, 32'h1234_5005);
        chk("ldfetch_lat", lat, FULL_LAT);

        // Reset in the middle of a wait period.
        req_addr = 32'h20; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rstwait_req_ready", req_ready, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_resp", resp_valid, 1'b0);
            tick();
        end
        fetch(32'h8, d, e, lat);
        chk("retain_data", d, 32'h8002_0109);
        chk("retain_lat", lat, FULL_LAT);

        // Sequential fetches: next word comes from the buffer when enabled.
        fetch(32'h4, d, e, lat);
        chk("seq0_lat", lat, FULL_LAT);
        fetch(32'h8, d, e, lat);
        chk("seq1_lat", lat, HIT_LAT);
        chk("seq1_data", d, 32'h8002_0109);
        fetch(32'h4, d, e, lat);
        ld_valid = 1'b1; ld_addr = IDX_W'(2); ld_data = 32'h8002_0BBB;
        tick();
        ld_valid = 1'b0;
        fetch(32'h8, d, e, lat);
        chk("inval_lat", lat, FULL_LAT);
        chk("inval_data", d, 32'h8002_0BBB);
        fetch(32'(DEPTH - 1) * 32'd4, d, e, lat);
        chk("top_err", e, 1'b0);
        fetch(32'h0, d, e, lat);
        chk("after_top_lat", lat, FULL_LAT);

        // Randomized traffic; the per-cycle compare checks every cycle.
        last_idx = 0;
        for (int i = 0; i < 2500; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            ld_valid   = ($urandom_range(0, 99) < 20);
            ld_addr    = ($urandom_range(0, 1) == 0) ? IDX_W'((last_idx + 1) % DEPTH)
                                                     : IDX_W'($urandom_range(0, DEPTH - 1));
            ld_data    = $urandom;
            req_valid  = ($urandom_range(0, 99) < 60);
            resp_ready = ($urandom_range(0, 99) < 70);
            k = $urandom_range(0, 9);
            if (k <= 4) begin
                last_idx = (last_idx + 1) % DEPTH;
                req_addr = 32'(last_idx) * 32'd4;
            end else if (k <= 6) begin
                last_idx = $urandom_range(0, DEPTH - 1);
                req_addr = 32'(last_idx) * 32'd4;
            end else if (k == 7) begin
                req_addr = (32'($urandom_range(0, DEPTH - 1)) * 32'd4) | 32'($urandom_range(1, 3));
            end else if (k == 8) begin
                req_addr = ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
            end else begin
                last_idx = DEPTH - 1;
                req_addr = 32'(last_idx) * 32'd4;
            end
            tick();
        end

        rst = 1'b0; req_valid = 1'b0; ld_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
